// File: rtl/cpu_regwrite_arbiter_pkg.sv
// rtl/cpu_regwrite_arbiter_pkg.sv - shared register-file constants and types for the writeback arbiter
package cpu_regwrite_arbiter_pkg;

    localparam int REG_COUNT = 16;
    localparam int REG_IDX_W = 4;
    localparam int DATA_W    = 32;
    localparam int FP_IDX    = 0;
    localparam int SP_IDX    = 1;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [REG_COUNT-1:0] reg_mask_t;
    typedef logic [DATA_W-1:0]    reg_data_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_EX   = 2'd1,
        GRANT_MEM  = 2'd2
    } grant_e;

    function automatic reg_mask_t idx_mask(input reg_idx_t idx);
        return reg_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// rtl/cpu_scoreboard.sv - pending-load busy vector and decode read-after-load hazard detect
module cpu_scoreboard
    import cpu_regwrite_arbiter_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      set_i,
    input  reg_idx_t  set_index_i,
    input  logic      clr_i,
    input  reg_idx_t  clr_index_i,
    input  reg_idx_t  rd_index0_i,
    input  reg_idx_t  rd_index1_i,
    input  logic      wr_en_i,
    input  reg_idx_t  wr_index_i,
    output reg_mask_t busy_o,
    output logic      hazard_o
);

    reg_mask_t r_busy;
    reg_mask_t w_set_mask;
    reg_mask_t w_clr_mask;
    logic      w_wr_hit;

    assign w_set_mask = set_i ? idx_mask(set_index_i) : '0;
    assign w_clr_mask = clr_i ? idx_mask(clr_index_i) : '0;

    // Set is applied after clear so a fresh load to the same register stays pending.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign w_wr_hit = wr_en_i && ((wr_index_i == rd_index0_i) || (wr_index_i == rd_index1_i));
    assign hazard_o = r_busy[rd_index0_i] | r_busy[rd_index1_i] | w_wr_hit;
    assign busy_o   = r_busy;

endmodule

// File: rtl/cpu_regwrite_arbiter.sv
// rtl/cpu_regwrite_arbiter.sv - shares register-file write port 0 between EX results and MEM load returns
module cpu_regwrite_arbiter
    import cpu_regwrite_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [REG_IDX_W-1:0] ex_index_i,
    input  logic [DATA_W-1:0]    ex_value_i,
    input  logic                 mem_valid_i,
    output logic                 mem_ready_o,
    input  logic [REG_IDX_W-1:0] mem_index_i,
    input  logic [DATA_W-1:0]    mem_value_i,
    input  logic                 load_issue_i,
    input  logic [REG_IDX_W-1:0] load_index_i,
    input  logic [REG_IDX_W-1:0] rd_index0_i,
    input  logic [REG_IDX_W-1:0] rd_index1_i,
    output logic                 hazard_o,
    output logic [REG_COUNT-1:0] busy_o,
    output logic                 rf_we_o,
    output logic [REG_IDX_W-1:0] rf_index_o,
    output logic [DATA_W-1:0]    rf_value_o
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    grant_e     w_grant;
    logic       w_ex_fire;
    logic       w_mem_fire;
    logic [CNT_W-1:0] r_starve;
    logic       r_we;
    reg_idx_t   r_index;
    reg_data_t  r_value;

    // MEM has priority; EX only overrides it once it has waited STARVE_LIMIT cycles.
    always_comb begin
        w_grant = GRANT_NONE;
        if (rst_i) begin
            if (ex_valid_i && (!mem_valid_i || (r_starve == LIMIT))) begin
                w_grant = GRANT_EX;
            end else if (mem_valid_i) begin
                w_grant = GRANT_MEM;
            end
        end
    end

    assign ex_ready_o  = (w_grant == GRANT_EX);
    assign mem_ready_o = (w_grant == GRANT_MEM);
    assign w_ex_fire   = ex_valid_i & ex_ready_o;
    assign w_mem_fire  = mem_valid_i & mem_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_starve <= '0;
        end else if (!ex_valid_i || ex_ready_o) begin
            r_starve <= '0;
        end else if (r_starve != LIMIT) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_we    <= 1'b0;
            r_index <= '0;
            r_value <= '0;
        end else if (w_ex_fire) begin
            r_we    <= 1'b1;
            r_index <= ex_index_i;
            r_value <= ex_value_i;
        end else if (w_mem_fire) begin
            r_we    <= 1'b1;
            r_index <= mem_index_i;
            r_value <= mem_value_i;
        end else begin
            r_we    <= 1'b0;
        end
    end

    // Gating with reset keeps a write registered just before reset from reaching the register file.
    assign rf_we_o    = r_we & rst_i;
    assign rf_index_o = r_index;
    assign rf_value_o = r_value;

    cpu_scoreboard u_scoreboard (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_i       (load_issue_i),
        .set_index_i (load_index_i),
        .clr_i       (w_mem_fire),
        .clr_index_i (mem_index_i),
        .rd_index0_i (rd_index0_i),
        .rd_index1_i (rd_index1_i),
        .wr_en_i     (rf_we_o),
        .wr_index_i  (rf_index_o),
        .busy_o      (busy_o),
        .hazard_o    (hazard_o)
    );

endmodule

// File: tb/tb_cpu_regwrite_arbiter.sv
// tb/tb_cpu_regwrite_arbiter.sv - directed self-checking bench for cpu_regwrite_arbiter
module tb_cpu_regwrite_arbiter;

    localparam int LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, mem_valid_i, load_issue_i;
    logic        ex_ready_o, mem_ready_o, hazard_o, rf_we_o;
    logic [3:0]  ex_index_i, mem_index_i, load_index_i, rd_index0_i, rd_index1_i, rf_index_o;
    logic [31:0] ex_value_i, mem_value_i, rf_value_o;
    logic [15:0] busy_o;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [35:0] q_wr[$];
    logic [15:0] m_busy = '0;
    int          m_starve = 0;
    logic [3:0]  m_idx = '0;
    logic [31:0] m_val = '0;
    logic        g_ex_ready;

    always #5 clk = ~clk;

    cpu_regwrite_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .ex_index_i   (ex_index_i),
        .ex_value_i   (ex_value_i),
        .mem_valid_i  (mem_valid_i),
        .mem_ready_o  (mem_ready_o),
        .mem_index_i  (mem_index_i),
        .mem_value_i  (mem_value_i),
        .load_issue_i (load_issue_i),
        .load_index_i (load_index_i),
        .rd_index0_i  (rd_index0_i),
        .rd_index1_i  (rd_index1_i),
        .hazard_o     (hazard_o),
        .busy_o       (busy_o),
        .rf_we_o      (rf_we_o),
        .rf_index_o   (rf_index_o),
        .rf_value_o   (rf_value_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of checking against the reference model, then advance the model across the edge.
    task automatic step();
        logic        exp_we, exp_ex, exp_mem, exp_haz;
        logic [35:0] w;
        @(negedge clk);
        exp_we = rst_i && (q_wr.size() != 0);
        if (q_wr.size() != 0) begin
            w     = q_wr.pop_front();
            m_idx = w[35:32];
            m_val = w[31:0];
        end
        chk("rf_we", {31'd0, rf_we_o}, {31'd0, exp_we});
        chk("rf_index", {28'd0, rf_index_o}, {28'd0, m_idx});
        chk("rf_value", rf_value_o, m_val);
        chk("busy", {16'd0, busy_o}, {16'd0, m_busy});
        exp_haz = m_busy[rd_index0_i] | m_busy[rd_index1_i]
                | (exp_we && (m_idx == rd_index0_i || m_idx == rd_index1_i));
        chk("hazard", {31'd0, hazard_o}, {31'd0, exp_haz});
        exp_ex  = rst_i && ex_valid_i && (!mem_valid_i || m_starve == LIMIT);
        exp_mem = rst_i && mem_valid_i && !exp_ex;
        chk("ex_ready", {31'd0, ex_ready_o}, {31'd0, exp_ex});
        chk("mem_ready", {31'd0, mem_ready_o}, {31'd0, exp_mem});
        chk("one_grant", {31'd0, ex_ready_o & mem_ready_o}, 32'd0);
        g_ex_ready = ex_ready_o;
        if (!rst_i) begin
            m_busy = '0; m_starve = 0; m_idx = '0; m_val = '0;
            q_wr.delete();
        end else begin
            if (exp_ex)       q_wr.push_back({ex_index_i, ex_value_i});
            else if (exp_mem) q_wr.push_back({mem_index_i, mem_value_i});
            if (!ex_valid_i || exp_ex) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (exp_mem)      m_busy[mem_index_i] = 1'b0;
            if (load_issue_i) m_busy[load_index_i] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b0; ex_valid_i = 1'b1; mem_valid_i = 1'b1; load_issue_i = 1'b1;
        ex_index_i = 4'd2; ex_value_i = 32'h1111_0000; mem_index_i = 4'd4; mem_value_i = 32'h2222_0000;
        load_index_i = 4'd6; rd_index0_i = 4'd0; rd_index1_i = 4'd0;
        @(posedge clk);
        #1;
        step();
        step();

        rst_i = 1'b1; ex_valid_i = 1'b0; mem_valid_i = 1'b0; load_issue_i = 1'b0;
        step();

        ex_valid_i = 1'b1; ex_index_i = 4'd3; ex_value_i = 32'hDEADBEEF;
        step();
        ex_valid_i = 1'b0;
        #1;
        chk("lone_ex_we", {31'd0, rf_we_o}, 32'd1);
        chk("lone_ex_idx", {28'd0, rf_index_o}, 32'd3);
        chk("lone_ex_val", rf_value_o, 32'hDEADBEEF);
        step();
        step();

        ex_valid_i = 1'b1; mem_valid_i = 1'b1;
        ex_index_i = 4'd1; ex_value_i = 32'hE000_0000;
        mem_index_i = 4'd8; mem_value_i = 32'hA000_0000;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("grant_seq", {31'd0, g_ex_ready}, {31'd0, (i % 3) == 2});
            if (g_ex_ready) begin
                ex_index_i = ex_index_i + 4'd1; ex_value_i = ex_value_i + 32'd1;
            end else begin
                mem_index_i = mem_index_i + 4'd1; mem_value_i = mem_value_i + 32'd1;
            end
        end
        ex_valid_i = 1'b0; mem_valid_i = 1'b0;
        step();
        step();

        load_issue_i = 1'b1; load_index_i = 4'd5;
        step();
        load_issue_i = 1'b0; rd_index0_i = 4'd5;
        #1;
        chk("busy_after_issue", {16'd0, busy_o}, 32'h0000_0020);
        chk("hazard_busy", {31'd0, hazard_o}, 32'd1);
        step();
        mem_valid_i = 1'b1; mem_index_i = 4'd5; mem_value_i = 32'h5555_AAAA;
        step();
        mem_valid_i = 1'b0;
        #1;
        chk("busy_cleared", {16'd0, busy_o}, 32'd0);
        chk("hazard_fwd", {31'd0, hazard_o}, 32'd1);
        step();
        #1;
        chk("hazard_gone", {31'd0, hazard_o}, 32'd0);
        rd_index0_i = 4'd0;

        load_issue_i = 1'b1; load_index_i = 4'd7;
        mem_valid_i = 1'b1; mem_index_i = 4'd7; mem_value_i = 32'h7777_0007;
        step();
        load_issue_i = 1'b0; mem_valid_i = 1'b0; rd_index1_i = 4'd7;
        #1;
        chk("set_wins", {16'd0, busy_o}, 32'h0000_0080);
        step();
        mem_valid_i = 1'b1; mem_value_i = 32'h7777_0008;
        step();
        mem_valid_i = 1'b0;
        step();
        step();
        rd_index1_i = 4'd0;

        ex_valid_i = 1'b1; ex_index_i = 4'd9; ex_value_i = 32'h1234_5678;
        load_issue_i = 1'b1; load_index_i = 4'd2;
        step();
        ex_valid_i = 1'b0; load_issue_i = 1'b0; rst_i = 1'b0;
        #1;
        chk("rst_discard_we", {31'd0, rf_we_o}, 32'd0);
        step();
        rst_i = 1'b1;
        #1;
        chk("rst_busy", {16'd0, busy_o}, 32'd0);
        chk("rst_we", {31'd0, rf_we_o}, 32'd0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
